// File: rtl/gaus_frame_sequencer_pkg.sv
// Shared types and constants for the 5x5 Gaussian frame sequencer:
// FSM state encoding, result pipeline depth and the kernel weights.
package gaus_frame_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        HOLD,
        DRAIN,
        DONE
    } seqState_t;

    localparam int PIPE_LAT  = 2;
    localparam int GAUS_TAPS = 5;

    // Binomial 5x5 kernel; weights sum to 256 so the result normalises with a shift.
    localparam int GAUS_NORM_SHIFT = 8;
    localparam logic [7:0] GAUS_WEIGHTS [GAUS_TAPS][GAUS_TAPS] = '{
        '{8'd1, 8'd4,  8'd6,  8'd4,  8'd1},
        '{8'd4, 8'd16, 8'd24, 8'd16, 8'd4},
        '{8'd6, 8'd24, 8'd36, 8'd24, 8'd6},
        '{8'd4, 8'd16, 8'd24, 8'd16, 8'd4},
        '{8'd1, 8'd4,  8'd6,  8'd4,  8'd1}
    };

endpackage

// File: rtl/gaus_frame_sequencer_beat_timer.sv
// Modulo-BEATS beat counter pacing the work done for each centre pixel.
module beat_timer #(
    parameter int BEATS = 4,
    parameter int BW    = $clog2(BEATS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          clear,
    output logic [BW-1:0] beat,
    output logic          last
);

    logic [BW-1:0] r_beat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_beat <= '0;
        end else if (clear) begin
            r_beat <= '0;
        end else if (enable) begin
            r_beat <= last ? '0 : r_beat + BW'(1);
        end
    end

    assign beat = r_beat;
    assign last = (r_beat == BW'(BEATS - 1));

endmodule

// File: rtl/gaus_frame_sequencer.sv
// Walks the interior pixels of a frame, loading window columns and tracking
// each centre through the multiplier pipeline to its result.
module gaus_frame_sequencer
    import gaus_frame_sequencer_pkg::*;
#(
    parameter int IMG_W = 1024,
    parameter int IMG_H = 2048,
    parameter int BEATS = 4,
    parameter int PICW  = 24
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic            downstreamReady,
    output logic            busy,
    output logic            done,
    output logic            bufferLoadEn,
    output logic [PICW-1:0] bufferReadAddr,
    output logic            multiplierEn,
    output logic            resultValid,
    output logic [PICW-1:0] resultAddr,
    output logic [PICW-1:0] pixelCount
);

    localparam int BW = $clog2(BEATS);
    localparam logic [PICW-1:0] FIRST_CENTRE = PICW'(2 * IMG_W + 2);
    localparam logic [PICW-1:0] LAST_CENTRE  = PICW'((IMG_H - 3) * IMG_W + IMG_W - 3);
    localparam logic [PICW-1:0] LAST_COL     = PICW'(IMG_W - 3);

    seqState_t       r_state;
    logic [PICW-1:0] r_centre;
    logic [PICW-1:0] r_col;
    logic            r_drain;
    logic [PICW-1:0] r_pixelCount;
    logic            r_pipeValid [PIPE_LAT];
    logic [PICW-1:0] r_pipeAddr  [PIPE_LAT];

    logic [BW-1:0]   w_beat;
    logic            w_lastBeat;
    logic            w_beatZero;
    logic            w_stall;
    logic            w_active;
    logic            w_startPass;
    logic            w_beatEnable;
    logic            w_beatClear;

    assign w_beatZero   = (w_beat == '0);
    assign w_stall      = w_beatZero && !downstreamReady;
    assign w_active     = (r_state == RUN) || (r_state == HOLD) || (r_state == DRAIN);
    assign w_startPass  = (r_state == IDLE) && start && !abort;
    assign w_beatEnable = (r_state == RUN) && !w_stall && !abort;
    assign w_beatClear  = (r_state != RUN) || abort;

    beat_timer #(
        .BEATS (BEATS),
        .BW    (BW)
    ) u_beatTimer (
        .clk    (clk),
        .reset  (reset),
        .enable (w_beatEnable),
        .clear  (w_beatClear),
        .beat   (w_beat),
        .last   (w_lastBeat)
    );

    // A stall is only taken at beat 0, so a centre already being loaded always finishes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_centre <= '0;
            r_col    <= '0;
            r_drain  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_startPass) begin
                        r_state  <= RUN;
                        r_centre <= FIRST_CENTRE;
                        r_col    <= PICW'(2);
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (w_stall) begin
                        r_state <= HOLD;
                    end else if (w_lastBeat) begin
                        if (r_centre == LAST_CENTRE) begin
                            r_state <= DRAIN;
                            r_drain <= 1'b0;
                        end else if (r_col == LAST_COL) begin
                            r_centre <= r_centre + PICW'(5);
                            r_col    <= PICW'(2);
                        end else begin
                            r_centre <= r_centre + PICW'(1);
                            r_col    <= r_col + PICW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (downstreamReady) begin
                        r_state <= RUN;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (r_drain) begin
                        r_state <= DONE;
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Result pipeline mirrors the multiplier latency; abort flushes anything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_pipeValid[i] <= 1'b0;
                r_pipeAddr[i]  <= '0;
            end
            r_pixelCount <= '0;
        end else begin
            if (abort && w_active) begin
                for (int i = 0; i < PIPE_LAT; i++) begin
                    r_pipeValid[i] <= 1'b0;
                end
            end else begin
                r_pipeValid[0] <= multiplierEn;
                for (int i = 1; i < PIPE_LAT; i++) begin
                    r_pipeValid[i] <= r_pipeValid[i-1];
                end
            end
            r_pipeAddr[0] <= r_centre;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_pipeAddr[i] <= r_pipeAddr[i-1];
            end
            if (w_startPass) begin
                r_pixelCount <= '0;
            end else if (resultValid) begin
                r_pixelCount <= r_pixelCount + PICW'(1);
            end
        end
    end

    assign busy           = w_active;
    assign done           = (r_state == DONE);
    assign bufferLoadEn   = (r_state == RUN) && w_beatZero && downstreamReady && !abort;
    assign bufferReadAddr = bufferLoadEn ? r_centre + PICW'(2) : '0;
    assign multiplierEn   = (r_state == RUN) && w_lastBeat;
    assign resultValid    = r_pipeValid[PIPE_LAT-1];
    assign resultAddr     = resultValid ? r_pipeAddr[PIPE_LAT-1] : '0;
    assign pixelCount     = r_pixelCount;

endmodule

// File: tb/tb_gaus_frame_sequencer.sv
// Directed bench for gaus_frame_sequencer on an 8x8 frame with 4 beats per pixel.
module tb_gaus_frame_sequencer;

    localparam int IMG_W = 8;
    localparam int IMG_H = 8;
    localparam int BEATS = 4;
    localparam int PICW  = 24;
    localparam int N_RESULTS = (IMG_W - 4) * (IMG_H - 4);

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic            abort;
    logic            downstreamReady;
    logic            busy;
    logic            done;
    logic            bufferLoadEn;
    logic [PICW-1:0] bufferReadAddr;
    logic            multiplierEn;
    logic            resultValid;
    logic [PICW-1:0] resultAddr;
    logic [PICW-1:0] pixelCount;

    int assertCount = 0;
    int failCount   = 0;
    int cycleNum    = 0;

    int resultAddrs[$];
    int resultCycles[$];
    int mulCycles[$];
    int loadAddrs[$];
    int expAddr[$];
    int doneCount;
    int doneCycle;
    int loadsNotReady;

    gaus_frame_sequencer #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .BEATS (BEATS),
        .PICW  (PICW)
    ) dut (
        .clk             (clock),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .downstreamReady (downstreamReady),
        .busy            (busy),
        .done            (done),
        .bufferLoadEn    (bufferLoadEn),
        .bufferReadAddr  (bufferReadAddr),
        .multiplierEn    (multiplierEn),
        .resultValid     (resultValid),
        .resultAddr      (resultAddr),
        .pixelCount      (pixelCount)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycleNum++;

    // Event log sampled mid-cycle, away from the active edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (multiplierEn) mulCycles.push_back(cycleNum);
            if (resultValid) begin
                resultAddrs.push_back(int'(resultAddr));
                resultCycles.push_back(cycleNum);
            end
            if (bufferLoadEn) loadAddrs.push_back(int'(bufferReadAddr));
            if (bufferLoadEn && !downstreamReady) loadsNotReady++;
            if (done) begin
                doneCount++;
                doneCycle = cycleNum;
            end
        end
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic r, input int cycles);
        start           = s;
        abort           = a;
        downstreamReady = r;
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    task automatic clearLog();
        resultAddrs.delete();
        resultCycles.delete();
        mulCycles.delete();
        loadAddrs.delete();
        doneCount     = 0;
        doneCycle     = 0;
        loadsNotReady = 0;
    endtask

    function automatic int qAt(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic waitDone(input string tag, input int budget);
        int n = 0;
        while (doneCount == 0 && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput(tag, int'(doneCount > 0), 1);
    endtask

    task automatic waitResults(input string tag, input int count, input int budget);
        int n = 0;
        while (resultAddrs.size() < count && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput(tag, int'(resultAddrs.size() >= count), 1);
    endtask

    task automatic checkSequence(input string tag);
        checkOutput({tag, "_count"}, resultAddrs.size(), N_RESULTS);
        for (int i = 0; i < N_RESULTS; i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), qAt(resultAddrs, i), expAddr[i]);
        end
    endtask

    task automatic pulseStart();
        applyStimulus(1'b1, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"},        int'(busy), 0);
        checkOutput({tag, "_done"},        int'(done), 0);
        checkOutput({tag, "_loadEn"},      int'(bufferLoadEn), 0);
        checkOutput({tag, "_readAddr"},    int'(bufferReadAddr), 0);
        checkOutput({tag, "_mulEn"},       int'(multiplierEn), 0);
        checkOutput({tag, "_valid"},       int'(resultValid), 0);
        checkOutput({tag, "_resultAddr"},  int'(resultAddr), 0);
        checkOutput({tag, "_pixelCount"},  int'(pixelCount), 0);
    endtask

    initial begin
        int startCycle;
        int lastIdx;
        int savedCount;

        for (int r = 2; r <= IMG_H - 3; r++) begin
            for (int c = 2; c <= IMG_W - 3; c++) begin
                expAddr.push_back(r * IMG_W + c);
            end
        end
        clearLog();

        $display("[TB] reset state");
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 3);
        checkAllZero("reset");
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 2);

        $display("[TB] full pass with ready high");
        clearLog();
        startCycle = cycleNum;
        pulseStart();
        waitDone("pass1_done", 300);
        checkSequence("pass1");
        checkOutput("pass1_pixelCount", int'(pixelCount), N_RESULTS);
        checkOutput("pass1_firstMulLatency", qAt(mulCycles, 0) - startCycle, 4);
        checkOutput("pass1_firstResultLatency", qAt(resultCycles, 0) - qAt(mulCycles, 0), 2);
        lastIdx = N_RESULTS - 1;
        checkOutput("pass1_lastResultLatency", qAt(resultCycles, lastIdx) - qAt(mulCycles, lastIdx), 2);
        checkOutput("pass1_doneAfterLast", doneCycle - qAt(resultCycles, lastIdx), 1);
        checkOutput("pass1_loadCount", loadAddrs.size(), N_RESULTS);
        checkOutput("pass1_firstLoadAddr", qAt(loadAddrs, 0), 20);
        checkOutput("pass1_wrapLoadAddr", qAt(loadAddrs, 4), 28);
        applyStimulus(1'b0, 1'b0, 1'b1, 5);
        checkOutput("pass1_donePulses", doneCount, 1);
        checkOutput("pass1_idleBusy", int'(busy), 0);

        $display("[TB] start while busy is ignored");
        clearLog();
        pulseStart();
        applyStimulus(1'b0, 1'b0, 1'b1, 20);
        checkOutput("busyMidPass", int'(busy), 1);
        pulseStart();
        waitDone("restartIgnored_done", 300);
        applyStimulus(1'b0, 1'b0, 1'b1, 10);
        checkOutput("restartIgnored_count", resultAddrs.size(), N_RESULTS);
        checkOutput("restartIgnored_pixelCount", int'(pixelCount), N_RESULTS);
        checkOutput("restartIgnored_idle", int'(busy), 0);

        $display("[TB] downstream hold");
        clearLog();
        pulseStart();
        waitResults("hold_reach6", 6, 100);
        savedCount = resultAddrs.size();
        startCycle = loadAddrs.size();
        applyStimulus(1'b0, 1'b0, 1'b0, 10);
        checkOutput("hold_fewResults", int'(resultAddrs.size() - savedCount <= 1), 1);
        checkOutput("hold_noLoads", loadAddrs.size() - startCycle, 0);
        checkOutput("hold_busy", int'(busy), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 0);
        waitDone("hold_done", 300);
        checkSequence("hold");
        checkOutput("hold_loadsNotReady", loadsNotReady, 0);
        checkOutput("hold_pixelCount", int'(pixelCount), N_RESULTS);

        $display("[TB] abort after five results");
        clearLog();
        pulseStart();
        waitResults("abort_reach5", 5, 100);
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        checkOutput("abort_busyLow", int'(busy), 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 40);
        checkOutput("abort_resultCount", resultAddrs.size(), 5);
        checkOutput("abort_noDone", doneCount, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 5);
        checkOutput("abortWinsStart", int'(busy), 0);
        clearLog();
        pulseStart();
        waitDone("afterAbort_done", 300);
        checkSequence("afterAbort");

        $display("[TB] reset mid-pass");
        clearLog();
        pulseStart();
        applyStimulus(1'b0, 1'b0, 1'b1, 30);
        #2 reset = 1'b1;
        #1;
        checkAllZero("asyncReset");
        applyStimulus(1'b0, 1'b0, 1'b1, 2);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 100);
        checkOutput("asyncReset_noDone", doneCount, 0);
        checkOutput("asyncReset_idle", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
